serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised digit-serial adder.
- Adds two WIDTH-bit operands plus carry-in over WIDTH/DIGIT clock cycles, DIGIT bits per cycle, through a small combinational ripple slice.
- Start/busy/done handshake; registered sum and carry-out held until the next operation.
- Generic arithmetic building block for area-constrained datapaths in the design.

Parameters:
- WIDTH, 8: operand and sum width in bits; must be >= 1.
- DIGIT, 1: bits processed per cycle; must be >= 1 and divide WIDTH exactly.
- NDIG is derived, not a parameter: NDIG = WIDTH/DIGIT, the number of digit cycles.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  carry-in; captured on an accepted start.
- busy  output  1  high while digits are being processed (RUN).
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  result bits (a+b+cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry register and digit counter are cleared.
  - Reset has priority over everything, including mid-RUN; a partial result is discarded, never shown.
- State machine:
  - IDLE -> RUN when start=1. On that edge: a, b, cin are latched; counter=0; carry register=cin.
  - RUN: on each edge the low DIGIT bits of the A/B shift registers and the carry register are added. The DIGIT result bits shift into the result register from the MSB side, operands shift right by DIGIT, carry register takes the slice carry-out, counter increments.
  - RUN -> DONE on the edge processing digit NDIG-1. On that edge sum <= completed result register and cout <= final slice carry.
  - DONE -> IDLE unconditionally after one cycle.
- Timing: start high in cycle 0 (IDLE) gives busy=1 in cycles 1..NDIG and done=1 in cycle NDIG+1 only. Latency from start to done is NDIG+1 cycles.
- start is ignored in RUN and DONE; it is not queued. Back-to-back throughput is one operation per NDIG+2 cycles.
- a, b and cin may change freely after the accepting edge; the result depends only on the captured values.
- sum and cout change only on the RUN->DONE edge or on reset. They hold between operations, including while the next operation is busy.
- Wrap-around: the carry out of the MSB appears only on cout; sum is truncated to WIDTH bits.
- DIGIT=WIDTH is legal: NDIG=1, one RUN cycle, latency 2.
- The counter width is clog2(NDIG) with a minimum of 1.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), captured with the operands on start.
  - When captured sub=1: B is captured inverted and the initial carry is forced to 1, so sum = (a - b) mod 2^WIDTH, cin is ignored, and cout = 1 means no borrow (a >= b).
  - When captured sub=0: behaviour is identical to the undefined case.
- Undefined: no sub port; addition only.

Decomposition:
- Package serial_adder_pkg holds:
  - State typedef: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Function computing NDIG and the counter width.
- Sub-module digit_adder #(DIGIT): purely combinational DIGIT-bit ripple of full-adder cells.
  - Inputs x[DIGIT], y[DIGIT], ci.
  - Outputs s[DIGIT], co.
  - The one natural split; the FSM, shift registers and counter stay in serial_adder.

Test Plan:
- WIDTH=8, DIGIT=1; start with a=8'h0F, b=8'h01, cin=0 -> busy high exactly 8 cycles; done pulses in cycle 9; sum=8'h10, cout=0.
- WIDTH=8, DIGIT=1; a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1 (full carry ripple and wrap).
- WIDTH=8, DIGIT=4; a=8'hA5, b=8'h5B, cin=1 -> busy 2 cycles, done in cycle 3; sum=8'h01, cout=1.
- Start pulsed again during RUN, with a/b changed after acceptance -> second start ignored; result matches the captured operands; sum holds its previous value until done.
- rst asserted in the middle of RUN (cycle 4) -> next cycle busy=0, done=0, sum=0, cout=0, state IDLE; a new start afterwards completes correctly.
- SERIAL_ADDER_SUB_EN defined, WIDTH=8, DIGIT=2:
  - sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, cout=0.
  - sub=1, a=8'h07, b=8'h05 -> sum=8'h02, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit cycles needed to cover the operand width.
  function automatic int unsigned calc_ndig(int unsigned width, int unsigned digit);
    return width / digit;
  endfunction

  // Digit counter width; never narrower than one bit.
  function automatic int unsigned calc_cnt_w(int unsigned ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry slice built from full-adder cells.
module digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  // Ripple the carry through DIGIT full-adder cells, LSB first.
  always_comb begin
    logic c;
    c = ci;
    s = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    co = c;
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit a+b+cin over WIDTH/DIGIT cycles, DIGIT bits per cycle.
// Optional SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a-b (cout=1 means no borrow).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int unsigned CNT_W = calc_cnt_w(NDIG);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_res;
  logic [WIDTH-1:0]     r_sum;
  logic                 r_carry;
  logic                 r_cout;
  logic [CNT_W-1:0]     r_cnt;
  logic [DIGIT-1:0]     w_s;
  logic                 w_co;
  logic                 w_last;
  logic [WIDTH+DIGIT-1:0] w_cat;
  logic [WIDTH-1:0]     w_res_next;
  logic [WIDTH-1:0]     w_b_in;
  logic                 w_c_in;

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .x (r_a[DIGIT-1:0]),
    .y (r_b[DIGIT-1:0]),
    .ci(r_carry),
    .s (w_s),
    .co(w_co)
  );

  // Operand/carry values captured on an accepted start.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    // Subtract as a + ~b + 1; cin is ignored in that mode.
    w_b_in = sub ? ~b : b;
    w_c_in = sub | cin;
`else
    w_b_in = b;
    w_c_in = cin;
`endif
  end

  // New digit enters the result register from the MSB side.
  assign w_cat      = {w_s, r_res};
  assign w_res_next = WIDTH'(w_cat >> DIGIT);
  assign w_last     = (r_cnt == LAST_CNT);

  // Next-state and status outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Operand capture, digit shifting and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_a     <= a;
      r_b     <= w_b_in;
      r_carry <= w_c_in;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_res   <= w_res_next;
      r_carry <= w_co;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_co;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: three serial_adder instances (DIGIT = 1, 4, 2) share stimulus;
// a per-instance queue of expected {cout, sum} is popped whenever an instance pulses done.
module tb_serial_adder;

  localparam int unsigned W = 8;
  localparam int unsigned DIG_TAB [3] = '{1, 4, 2};

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy_v [3];
  logic         done_v [3];
  logic [W-1:0] sum_v  [3];
  logic         cout_v [3];

  logic [W:0]   q0 [$];
  logic [W:0]   q1 [$];
  logic [W:0]   q2 [$];
  logic [W-1:0] prev [3];

  int n_checks;
  int n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W), .DIGIT(DIG_TAB[0])) u_dut_d1 (
    .clk(clk), .rst(rst), .start(start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .a(a), .b(b), .cin(cin),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0])
  );

  serial_adder #(.WIDTH(W), .DIGIT(DIG_TAB[1])) u_dut_d4 (
    .clk(clk), .rst(rst), .start(start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .a(a), .b(b), .cin(cin),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1])
  );

  serial_adder #(.WIDTH(W), .DIGIT(DIG_TAB[2])) u_dut_d2 (
    .clk(clk), .rst(rst), .start(start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .a(a), .b(b), .cin(cin),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference result {cout, sum}.
  function automatic logic [W:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                       input logic tc, input logic ts);
    logic [W:0] r;
    if (ts) r = {1'b0, ta} + {1'b0, ~tb_} + (W+1)'(1);
    else    r = {1'b0, ta} + {1'b0, tb_} + (W+1)'(tc);
    return r;
  endfunction

  task automatic pop_chk(input int k);
    logic [W:0] e;
    int         n;
    case (k)
      0:       n = q0.size();
      1:       n = q1.size();
      default: n = q2.size();
    endcase
    check_eq($sformatf("exp_pending%0d", k), 32'(n > 0), 32'd1);
    if (n > 0) begin
      case (k)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check_eq($sformatf("sum_d%0d", DIG_TAB[k]), 32'(sum_v[k]), 32'(e[W-1:0]));
      check_eq($sformatf("cout_d%0d", DIG_TAB[k]), 32'(cout_v[k]), 32'(e[W]));
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) if (done_v[k] === 1'b1) pop_chk(k);
  end

  task automatic reset_checks(input string tag);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("%s_busy%0d", tag, k), 32'(busy_v[k]), 32'd0);
      check_eq($sformatf("%s_done%0d", tag, k), 32'(done_v[k]), 32'd0);
      check_eq($sformatf("%s_sum%0d", tag, k), 32'(sum_v[k]), 32'd0);
      check_eq($sformatf("%s_cout%0d", tag, k), 32'(cout_v[k]), 32'd0);
    end
  endtask

  // One operation with timing checks; operands are scrambled after acceptance, and with
  // 'again' set a second start is held during the first RUN cycle and must be ignored.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts, input bit again);
    int         busy_n [3];
    int         done_n [3];
    int         done_at[3];
    int         nd;
    logic [W:0] e;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
    e = model(ta, tb_, tc, ts);
    q0.push_back(e); q1.push_back(e); q2.push_back(e);
    for (int k = 0; k < 3; k++) begin busy_n[k] = 0; done_n[k] = 0; done_at[k] = 0; end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        a = ~ta; b = ta ^ 8'h3C; cin = ~tc; sub = ~ts;
        start = again;
      end else begin
        start = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        nd = int'(W / DIG_TAB[k]);
        if (c <= nd) check_eq($sformatf("sum_hold_d%0d", DIG_TAB[k]), 32'(sum_v[k]),
                              32'(prev[k]));
        if (busy_v[k] === 1'b1) busy_n[k]++;
        if (done_v[k] === 1'b1) begin
          done_n[k]++;
          done_at[k] = c;
          prev[k]    = e[W-1:0];
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      nd = int'(W / DIG_TAB[k]);
      check_eq($sformatf("busy_cycles_d%0d", DIG_TAB[k]), 32'(busy_n[k]), 32'(nd));
      check_eq($sformatf("done_count_d%0d", DIG_TAB[k]), 32'(done_n[k]), 32'd1);
      check_eq($sformatf("done_cycle_d%0d", DIG_TAB[k]), 32'(done_at[k]), 32'(nd + 1));
    end
  endtask

  // Reset asserted in cycle 4 of an operation, then a clean operation.
  task automatic reset_mid_run();
    logic [W:0] e;
    @(negedge clk);
    a = 8'h3C; b = 8'h4B; cin = 1'b1; sub = 1'b0; start = 1'b1;
    e = model(8'h3C, 8'h4B, 1'b1, 1'b0);
    q0.push_back(e); q1.push_back(e); q2.push_back(e);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      a     = ~a;
      if (c == 4) rst = 1'b1;
    end
    @(negedge clk);
    reset_checks("midrst");
    check_eq("d4_consumed", 32'(q1.size()), 32'd0);
    rst = 1'b0;
    q0.delete();
    q2.delete();
    for (int k = 0; k < 3; k++) prev[k] = '0;
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    for (int k = 0; k < 3; k++) prev[k] = '0;
    repeat (2) @(negedge clk);
    reset_checks("reset");
    rst = 1'b0;

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op(8'hA5, 8'h5B, 1'b1, 1'b0, 1'b0);
    run_op(8'h81, 8'h7E, 1'b0, 1'b0, 1'b1);
    reset_mid_run();
`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
    run_op(8'h07, 8'h05, 1'b0, 1'b1, 1'b1);
    run_op(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
`endif
    for (int i = 0; i < 6; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, bit'(i % 2));
    end
    repeat (3) @(negedge clk);
    check_eq("q0_drained", 32'(q0.size()), 32'd0);
    check_eq("q1_drained", 32'(q1.size()), 32'd0);
    check_eq("q2_drained", 32'(q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
